// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - forwarding selects, hazard stalls and multicycle interlock for the 5-stage pipeline
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   id_src, id_branch  ID-stage source registers (operand i at [i*AW +: AW]) and branch-in-ID flag
//   idex_*             ID/EX sources, regwrite, memread (load) and destination
//   exmem_*            EX/MEM regwrite, memread and destination
//   memwb_*            MEM/WB regwrite and destination
//   md_start           ID/EX holds a multicycle op entering EX
//   fwd_alu            per-operand ALU select (2 bits each): 00 regfile, 10 EX/MEM, 01 MEM/WB
//   fwd_br             per-operand branch comparator select: 1 = EX/MEM
//   stall, flush_idex  hold PC and IF/ID, bubble ID/EX
//   md_busy            multicycle unit busy
//   stall_count        saturating count of stall cycles
module hazard_forward_unit #(
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int REG_OUT = 1,
    parameter int MD_LAT  = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic                 id_branch,
    input  logic [NSRC*AW-1:0]   idex_src,
    input  logic                 idex_regwrite,
    input  logic                 idex_memread,
    input  logic [AW-1:0]        idex_rd,
    input  logic                 exmem_regwrite,
    input  logic                 exmem_memread,
    input  logic [AW-1:0]        exmem_rd,
    input  logic                 memwb_regwrite,
    input  logic [AW-1:0]        memwb_rd,
    input  logic                 md_start,
    output logic [2*NSRC-1:0]    fwd_alu,
    output logic [NSRC-1:0]      fwd_br,
    output logic                 stall,
    output logic                 flush_idex,
    output logic                 md_busy,
    output logic [CNT_W-1:0]     stall_count
);

    localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // A stage "hits" a register when it writes that register and it is not r0.
    function automatic logic hit(input logic we, input logic [AW-1:0] rd, input logic [AW-1:0] r);
        return we && (rd != '0) && (rd == r);
    endfunction

    logic [2*NSRC-1:0] alu_sel;
    logic [NSRC-1:0]   br_sel;
    logic              h_lu;
    logic              h_ba;
    logic              h_bl;
    logic [0:0]        state;
    logic [CW-1:0]     cnt;

    always_comb begin
        alu_sel = '0;
        br_sel  = '0;
        h_lu    = 1'b0;
        h_ba    = 1'b0;
        h_bl    = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            // EX/MEM holds the newer value, so it wins over MEM/WB.
            if (hit(exmem_regwrite, exmem_rd, idex_src[i*AW +: AW]))
                alu_sel[2*i +: 2] = 2'b10;
            else if (hit(memwb_regwrite, memwb_rd, idex_src[i*AW +: AW]))
                alu_sel[2*i +: 2] = 2'b01;
            // A load in EX/MEM has no data yet; the branch waits instead of forwarding.
            br_sel[i] = id_branch && hit(exmem_regwrite, exmem_rd, id_src[i*AW +: AW]) && !exmem_memread;
            h_lu = h_lu | hit(idex_memread, idex_rd, id_src[i*AW +: AW]);
            h_ba = h_ba | (id_branch && hit(idex_regwrite, idex_rd, id_src[i*AW +: AW]));
            h_bl = h_bl | (id_branch && hit(exmem_memread, exmem_rd, id_src[i*AW +: AW]));
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fwd_alu <= '0;
                    fwd_br  <= '0;
                end else begin
                    fwd_alu <= alu_sel;
                    fwd_br  <= br_sel;
                end
            end
        end else begin : g_comb
            assign fwd_alu = alu_sel;
            assign fwd_br  = br_sel;
        end
    endgenerate

    assign md_busy    = (state == ST_BUSY);
    assign stall      = h_lu | h_ba | h_bl | md_busy;
    // The multicycle op must stay in ID/EX while busy, so no bubble then.
    assign flush_idex = stall && !md_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_start && !stall) begin
                        state <= ST_BUSY;
                        cnt   <= CW'(MD_LAT - 1);
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule
